theta_slice_stage: RTL and testbench
====================================

Name: theta_slice_stage

Overview:
- Column-parity mixing stage of the matrix encoder; sits directly upstream of the add-round-constant stage.
- State is 64 slices of 25 bits; slice z is line z. Bit 5*y+x of a line is A[x][y], with x,y in 0..4.
- Two passes: pass 1 reads all 64 slices and builds the column-parity table. Pass 2 re-reads each slice and writes it back mixed.
- Reads use the same address-out/combinational-data-in scheme as the downstream stage: cnt_value drives the memory address, line_in returns the same cycle.

Parameters:
- SLICES, 64, number of slices per state (power of two; cnt_value width = log2(SLICES)).
- LANE_W, 25, bits per slice (fixed 5x5; not a free parameter for the mixing logic).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- theta_en  input  1  start request, edge-armed (see Behaviour).
- cnt_value  output  6  read address of the slice presented on line_in.
- line_in  input  25  slice data at cnt_value, combinational, same cycle.
- write_enable  output  1  write strobe for write_addr/write_value.
- write_addr  output  6  slice index being written.
- write_value  output  25  mixed slice.
- donee  output  1  one-cycle completion pulse.
- busy  output  1  high in PARITY, APPLY and DRAIN.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; cnt_value=0; write_enable=0; write_addr=0; write_value=0; donee=0; busy=0.
  - Parity table cleared; armed=1.
  - Applies at any time, including mid-pass, aborting the pass with no further writes.
- Arming:
  - armed clears when a run starts.
  - armed sets on any clock edge where theta_en=0.
  - A run starts only from IDLE with theta_en=1 and armed=1, so a held-high theta_en yields exactly one run.
  - theta_en is ignored outside IDLE.
- FSM: IDLE -> PARITY -> APPLY -> DRAIN -> DONE -> IDLE.
- PARITY (64 cycles):
  - cnt_value = k, k = 0..63.
  - Each edge stores C[x][k] = XOR over y of line_in[5y+x], for x = 0..4.
  - At k=63: cnt_value wraps to 0 and state goes to APPLY.
- APPLY (64 cycles):
  - cnt_value = k, k = 0..63.
  - D[x][k] = C[(x+4)%5][k] ^ C[(x+1)%5][(k+63)%64]. Slice index wraps: slice 0 uses C of slice 63.
  - Registered outputs on each edge: write_enable=1, write_addr=k, write_value[5y+x] = line_in[5y+x] ^ D[x][k].
  - Write latency is 1 cycle after the read address.
  - At k=63: state goes to DRAIN.
- DRAIN (1 cycle):
  - Outputs still show the write for slice 63.
  - The next edge drops write_enable, sets donee=1 and enters DONE.
- DONE (1 cycle): donee=1, busy=0, cnt_value=0; next edge clears donee and returns to IDLE.
- Outside the APPLY-registered cycles, write_enable=0 and write_addr/write_value hold their last values.
- Timing: if theta_en is sampled high at edge E0, writes are visible in cycles E65..E128 and donee is high in cycle E129. One run is 130 cycles.
- Writes target a separate output buffer. The stage never reads back its own writes within a run.

Test Plan:
- All-zero memory, theta_en=1 held -> 64 writes of 0 with write_addr 0..63 in order; donee exactly one cycle, 129 cycles after the start edge; no second run while theta_en stays high.
- mem[0]=0x0000001, rest 0 -> slice0 = 0x0210843, slice1 = 0x1084210, all other slices 0.
- Wrap: mem[63]=0x0000001, rest 0 -> slice63 = 0x0210843, slice0 = 0x1084210, all other slices 0.
- Parity cancel: every mem[k]=0x0000021 (A[0][0] and A[0][1]) -> every write_value = 0x0000021.
- Reset mid-run: rst=0 for 1 cycle during APPLY at k=20 -> outputs immediately at reset values, no donee. After rst=1 with theta_en low then high, a full clean run repeats the expected results.
- Pulse theta_en during PARITY -> ignored; exactly one donee. Re-arm (theta_en 0 for 1 cycle, then 1) -> second identical run.

Source files
------------

// File: rtl/theta_slice_stage.sv
// theta_slice_stage: column-parity mixing stage of the matrix encoder.
// Pass 1 reads all slices and stores the 5-bit column parity of each.
// Pass 2 re-reads every slice and emits it mixed with the parity of the
// neighbouring columns (same slice, x-1) and (previous slice, x+1).
module theta_slice_stage #(
  parameter int SLICES = 64,
  parameter int LANE_W = 25,
  localparam int CW = $clog2(SLICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              theta_en,
  output logic [CW-1:0]     cnt_value,
  input  logic [LANE_W-1:0] line_in,
  output logic              write_enable,
  output logic [CW-1:0]     write_addr,
  output logic [LANE_W-1:0] write_value,
  output logic              donee,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PARITY = 3'd1,
    S_APPLY  = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(SLICES - 1);

  // Column parity of one slice: bit x = XOR over y of A[x][y].
  function automatic logic [4:0] col_parity(input logic [24:0] s);
    logic [4:0] p;
    p = 5'd0;
    for (int y = 0; y < 5; y++) begin
      p = p ^ s[5*y +: 5];
    end
    return p;
  endfunction

  // Mix one slice with column parities of this slice and the previous one.
  function automatic logic [24:0] theta_mix(input logic [24:0] s,
                                            input logic [4:0]  c_cur,
                                            input logic [4:0]  c_prev);
    logic [4:0]  d;
    logic [24:0] r;
    for (int x = 0; x < 5; x++) begin
      d[x] = c_cur[(x + 4) % 5] ^ c_prev[(x + 1) % 5];
    end
    for (int y = 0; y < 5; y++) begin
      r[5*y +: 5] = s[5*y +: 5] ^ d;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                we_q, we_d;
  logic [CW-1:0]       waddr_q, waddr_d;
  logic [LANE_W-1:0]   wval_q, wval_d;
  logic                donee_q, donee_d;
  logic                busy_q, busy_d;
  logic                start_s;
  logic [CW-1:0]       prev_idx_s;
  logic [4:0]          par_q [SLICES];

  assign prev_idx_s = cnt_q - CW'(1);

  // Next-state, address sequencing, arming and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (theta_en && armed_q) begin
          start_s = 1'b1;
          state_d = S_PARITY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = S_APPLY;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_APPLY: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wval_d  = theta_mix(line_in, par_q[cnt_q], par_q[prev_idx_s]);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_APPLY;
        end
      end
      S_DRAIN: begin
        cnt_d   = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (start_s) begin
      armed_d = 1'b0;
    end else if (!theta_en) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    donee_d = (state_q == S_DRAIN);
    busy_d  = (state_d == S_PARITY) || (state_d == S_APPLY) || (state_d == S_DRAIN);
  end

  // State, counter and output registers; reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wval_q  <= '0;
      donee_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wval_q  <= wval_d;
      donee_q <= donee_d;
      busy_q  <= busy_d;
    end
  end

  // Parity table: one 5-bit column-parity entry per slice, filled in pass 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SLICES; i++) begin
        par_q[i] <= 5'd0;
      end
    end else if (state_q == S_PARITY) begin
      par_q[cnt_q] <= col_parity(line_in);
    end
  end

  assign cnt_value    = cnt_q;
  assign write_enable = we_q;
  assign write_addr   = waddr_q;
  assign write_value  = wval_q;
  assign donee        = donee_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_theta_slice_stage.sv
// Testbench for theta_slice_stage: random and directed slice memories,
// compared against a lane-array reference of the column-parity mixing.
module tb_theta_slice_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        theta_en;
  logic [5:0]  cnt_value;
  logic [24:0] line_in;
  logic        write_enable;
  logic [5:0]  write_addr;
  logic [24:0] write_value;
  logic        donee;
  logic        busy;

  logic [24:0] mem  [64];
  logic [24:0] expv [64];
  logic [24:0] got  [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign line_in = mem[cnt_value];

  theta_slice_stage dut (
    .clk          (clk),
    .rst          (rst),
    .theta_en     (theta_en),
    .cnt_value    (cnt_value),
    .line_in      (line_in),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_value  (write_value),
    .donee        (donee),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: view state as lanes A[x][y][z], compute column parities,
  // then every bit picks up C[x-1][z] ^ C[x+1][z-1].
  task automatic build_model();
    bit a [5][5][64];
    bit c [5][64];
    for (int z = 0; z < 64; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          a[x][y][z] = mem[z][5*y + x];
    for (int z = 0; z < 64; z++)
      for (int x = 0; x < 5; x++) begin
        c[x][z] = 1'b0;
        for (int y = 0; y < 5; y++) c[x][z] = c[x][z] ^ a[x][y][z];
      end
    for (int z = 0; z < 64; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          expv[z][5*y + x] = a[x][y][z] ^ c[(x + 4) % 5][z] ^ c[(x + 1) % 5][(z + 63) % 64];
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " cnt_value"}, 32'(cnt_value), 32'd0);
    check_eq({tag, " write_enable"}, 32'(write_enable), 32'd0);
    check_eq({tag, " write_addr"}, 32'(write_addr), 32'd0);
    check_eq({tag, " write_value"}, 32'(write_value), 32'd0);
    check_eq({tag, " donee"}, 32'(donee), 32'd0);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // One full run. hold=1 keeps theta_en high throughout; hold=0 drops it
  // after the start edge and pulses it once during the parity pass.
  task automatic do_run(input string tag, input bit hold);
    int wr_cnt;
    int done_cnt;
    build_model();
    for (int i = 0; i < 64; i++) got[i] = 25'h1ffffff;
    @(negedge clk); theta_en = 1'b0;
    @(negedge clk); theta_en = 1'b1;
    wr_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n <= 140; n++) begin
      @(posedge clk); #1;
      if (n <= 127) check_eq({tag, " cnt_value"}, 32'(cnt_value), 32'(n % 64));
      check_eq({tag, " busy"}, 32'(busy), (n <= 128) ? 32'd1 : 32'd0);
      if (write_enable) begin
        check_eq({tag, " write_addr"}, 32'(write_addr), 32'(wr_cnt));
        check_eq({tag, " write_cycle"}, 32'(n), 32'(65 + wr_cnt));
        check_eq({tag, " write_value"}, 32'(write_value), 32'(expv[write_addr]));
        got[write_addr] = write_value;
        wr_cnt++;
      end
      if (donee) begin
        done_cnt++;
        check_eq({tag, " donee_cycle"}, 32'(n), 32'd129);
      end
      if (!hold) begin
        if (n == 20) theta_en = 1'b1;
        else theta_en = 1'b0;
      end
    end
    check_eq({tag, " write_count"}, 32'(wr_cnt), 32'd64);
    check_eq({tag, " donee_count"}, 32'(done_cnt), 32'd1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
  endtask

  task automatic fill_const(input logic [24:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  initial begin
    int stray;
    rst = 1'b0;
    theta_en = 1'b0;
    fill_const(25'h0);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // All-zero memory with theta_en held high.
    do_run("zero", 1'b1);
    check_eq("zero slice5", 32'(got[5]), 32'd0);

    // Single bit in slice 0.
    fill_const(25'h0); mem[0] = 25'h0000001;
    do_run("bit0", 1'b1);
    check_eq("bit0 slice0", 32'(got[0]), 32'h0210843);
    check_eq("bit0 slice1", 32'(got[1]), 32'h1084210);
    check_eq("bit0 slice2", 32'(got[2]), 32'h0);
    check_eq("bit0 slice63", 32'(got[63]), 32'h0);

    // Single bit in slice 63: slice index wraps.
    fill_const(25'h0); mem[63] = 25'h0000001;
    do_run("wrap", 1'b1);
    check_eq("wrap slice63", 32'(got[63]), 32'h0210843);
    check_eq("wrap slice0", 32'(got[0]), 32'h1084210);
    check_eq("wrap slice62", 32'(got[62]), 32'h0);

    // Even column parity everywhere: data passes through unchanged.
    fill_const(25'h0000021);
    do_run("cancel", 1'b1);
    check_eq("cancel slice0", 32'(got[0]), 32'h21);
    check_eq("cancel slice40", 32'(got[40]), 32'h21);

    // Random memories.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      do_run("rand", 1'b1);
    end

    // Reset in the middle of the apply pass.
    fill_random();
    @(negedge clk); theta_en = 1'b0;
    @(negedge clk); theta_en = 1'b1;
    repeat (85) @(posedge clk);
    @(negedge clk);
    check_eq("midrst cnt_before", 32'(cnt_value), 32'd20);
    check_eq("midrst we_before", 32'(write_enable), 32'd1);
    rst = 1'b0;
    theta_en = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk); rst = 1'b1;
    stray = 0;
    for (int n = 0; n < 140; n++) begin
      @(posedge clk); #1;
      if (write_enable || donee || busy) stray++;
    end
    check_eq("midrst idle_activity", 32'(stray), 32'd0);
    do_run("after_rst", 1'b1);

    // Pulse during parity ignored, then a re-armed identical run.
    fill_random();
    do_run("pulse", 1'b0);
    do_run("rearm", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
